// File: rtl/text_line_renderer.sv
// text_line_renderer
// Overlays one scaled line of text on the VGA pixel stream. A small
// character buffer holds the string; each pixel coordinate is mapped to a
// character slot, glyph column and glyph row, the external 6x8 font ROM is
// addressed with the stored code, and the returned row bits are serialized
// into a one-bit text pixel. Two-stage pipeline, one pixel per clock.

module text_line_renderer #(
  parameter  int MAX_CHARS    = 16,
  parameter  int SCALE_LOG2   = 1,
  parameter  int BLINK_FRAMES = 30,
  localparam int AW           = $clog2(MAX_CHARS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  input  logic [9:0]    pixel_x,
  input  logic [9:0]    pixel_y,
  input  logic [9:0]    origin_x,
  input  logic [9:0]    origin_y,
  input  logic [AW:0]   text_len,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [6:0]    wr_data,
  input  logic          blink_en,
  input  logic          frame_tick,
  output logic [6:0]    rom_char_code,
  output logic [2:0]    rom_row,
  input  logic [5:0]    rom_row_bits,
  output logic          text_valid,
  output logic          text_pixel
);

  localparam int CW      = 32;
  localparam int GLYPH_H = 8 << SCALE_LOG2;
  localparam int BCW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [AW:0]    LEN_MAX  = (AW + 1)'(MAX_CHARS);
  localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_FRAMES - 1);

  // Character buffer
  logic [6:0] buffer [MAX_CHARS];

  // Stage-0 combinational geometry
  logic [AW:0]   len_c;
  logic [9:0]    rx;
  logic [9:0]    ry;
  logic [9:0]    cx;
  logic [9:0]    char_full;
  logic          in_box_c;
  logic [AW-1:0] char_idx_c;
  logic [2:0]    col_c;
  logic [2:0]    glyph_row_c;

  // Stage-1 registers
  logic          pix_en_s1;
  logic          in_box_s1;
  logic [AW-1:0] char_idx_s1;
  logic [2:0]    col_s1;
  logic [2:0]    glyph_row_s1;

  // Stage-2 helpers
  logic [2:0]    bit_sel;

  // Blink state
  logic [BCW-1:0] blink_cnt;
  logic           blink_phase;

  // Store incoming characters; reset blanks the whole line.
  // NOTE: the buffer is a handful of flops, not a RAM macro, so it is cleared
  // by reset; sequential state is always assigned with <= so every register
  // samples pre-edge values and the write/lookup ordering stays well defined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_CHARS; i++) begin
        buffer[i] <= '0;
      end
    end else if (wr_en) begin
      buffer[wr_addr] <= wr_data;
    end
  end

  // Map the pixel coordinate onto box membership, character slot, column and row.
  // NOTE: every variable gets a default before any condition so no latch can form.
  always_comb begin
    len_c       = text_len;
    rx          = pixel_x - origin_x;
    ry          = pixel_y - origin_y;
    cx          = '0;
    char_full   = '0;
    in_box_c    = 1'b0;
    char_idx_c  = '0;
    col_c       = '0;
    glyph_row_c = '0;

    if (text_len > LEN_MAX) begin
      len_c = LEN_MAX;
    end

    cx          = rx >> SCALE_LOG2;
    char_full   = cx / 10'd6;
    col_c       = 3'(cx - char_full * 10'd6);
    char_idx_c  = AW'(char_full);
    glyph_row_c = 3'(ry >> SCALE_LOG2);

    // rx < len*6*2^S is the same test as floor(rx/2^S)/6 < len, because the
    // box width is a whole multiple of both 2^S and 6; comparing the slot
    // index avoids a multiplier and also covers the full quotient width.
    in_box_c = (pixel_x >= origin_x) &&
               (pixel_y >= origin_y) &&
               (CW'(char_full) < CW'(len_c)) &&
               (CW'(ry) < CW'(GLYPH_H));
  end

  // Stage-1 register: geometry results travel with their pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_en_s1    <= 1'b0;
      in_box_s1    <= 1'b0;
      char_idx_s1  <= '0;
      col_s1       <= '0;
      glyph_row_s1 <= '0;
    end else begin
      pix_en_s1    <= pix_en;
      in_box_s1    <= in_box_c;
      char_idx_s1  <= char_idx_c;
      col_s1       <= col_c;
      glyph_row_s1 <= glyph_row_c;
    end
  end

  // Drive the font ROM; outside the box present the blank code.
  always_comb begin
    rom_char_code = '0;
    rom_row       = glyph_row_s1;
    if (in_box_s1) begin
      rom_char_code = buffer[char_idx_s1];
    end
  end

  // Bit 5 of the ROM row is the leftmost glyph column.
  always_comb begin
    bit_sel = 3'd5 - col_s1;
  end

  // Count frames and flip the blink phase every BLINK_FRAMES ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BCW'(1);
      end
    end
  end

  // Stage-2 register: pick the glyph bit and apply qualification and blink.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      text_valid <= 1'b0;
      text_pixel <= 1'b0;
    end else begin
      text_valid <= pix_en_s1;
      text_pixel <= pix_en_s1 & in_box_s1 & rom_row_bits[bit_sel] &
                    ~(blink_en & blink_phase);
    end
  end

endmodule
